// File: rtl/sound_pkg.sv
// ============================================================================
// sound_pkg : shared types and helpers for the sound mixer datapath.
// Revision  : 1.0
// ============================================================================
`default_nettype none

package sound_pkg;

`ifdef SOUND_MIXER_DC_BLOCK_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2,
    ST_DCB  = 2'd3
  } mix_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } mix_state_t;
`endif

  // Sum of CH_NUM products of a signed sample and a zero-extended volume.
  function automatic int unsigned acc_width(input int unsigned in_w,
                                            input int unsigned vol_w,
                                            input int unsigned ch_num);
    return in_w + vol_w + 1 + $clog2(ch_num);
  endfunction

  // Clamp a wide signed value into the range of a w-bit signed number.
  function automatic logic signed [63:0] sat_s(input logic signed [63:0] x,
                                               input int unsigned        w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sound_dsm.sv
// ============================================================================
// sound_dsm : first-order delta-sigma modulator, signed word in, 1-bit out.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module sound_dsm #(
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic [OUT_W-1:0] mix_in,
  output logic             pwm_out
);

  logic [OUT_W-1:0] r_dacc;
  logic             r_pwm;
  logic [OUT_W-1:0] w_u;
  logic [OUT_W:0]   w_sum;

  // Offset-binary view of the signed input: density tracks u / 2^OUT_W.
  assign w_u   = {~mix_in[OUT_W-1], mix_in[OUT_W-2:0]};
  assign w_sum = {1'b0, r_dacc} + {1'b0, w_u};

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_dacc <= '0;
      r_pwm  <= 1'b0;
    end else begin
      r_dacc <= w_sum[OUT_W-1:0];
      r_pwm  <= w_sum[OUT_W];
    end
  end

  assign pwm_out = r_pwm;

endmodule

`default_nettype wire

// File: rtl/sound_mixer_pwm.sv
// ============================================================================
// sound_mixer_pwm : time-multiplexed N-channel volume mixer with saturation
//                   and delta-sigma 1-bit output.
// Option          : SOUND_MIXER_DC_BLOCK_EN adds a DC-blocking high-pass.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module sound_mixer_pwm #(
  parameter int CH_NUM     = 4,
  parameter int IN_W       = 16,
  parameter int VOL_W      = 4,
  parameter int GAIN_SHIFT = 3,
  parameter int OUT_W      = 16,
  parameter int VOL_RESET  = 8
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic                     sample_en,
  input  logic [CH_NUM*IN_W-1:0]   ch_in,
  input  logic                     vol_we,
  input  logic [2:0]               vol_addr,
  input  logic [VOL_W-1:0]         vol_wdata,
  output logic signed [OUT_W-1:0]  mix_out,
  output logic                     mix_valid,
  output logic                     busy,
  output logic                     overrun,
  output logic                     pwm_out
);

  import sound_pkg::*;

  localparam int ACC_W  = acc_width(IN_W, VOL_W, CH_NUM);
  localparam int IDX_W  = $clog2(CH_NUM);
  localparam int PROD_W = IN_W + VOL_W + 1;

  mix_state_t r_state;
  mix_state_t w_state_nxt;

  logic        [VOL_W-1:0] r_vol    [CH_NUM];
  logic        [VOL_W-1:0] r_vol_sh [CH_NUM];
  logic signed [IN_W-1:0]  r_smp_sh [CH_NUM];

  logic signed [ACC_W-1:0] r_acc;
  logic        [IDX_W-1:0] r_idx;
  logic signed [OUT_W-1:0] r_mix;
  logic                    r_valid;
  logic                    r_busy;
  logic                    r_overrun;

  logic signed [IN_W-1:0]   w_smp_cur;
  logic        [VOL_W-1:0]  w_vol_cur;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_shift;
  logic signed [OUT_W-1:0]  w_sat;
  logic                     w_last;
  logic                     w_start;

  assign w_start = sample_en && (r_state == ST_IDLE);
  assign w_last  = (r_idx == IDX_W'(CH_NUM - 1));

  // Live volume registers and frame-start shadows; out-of-range writes match no channel.
  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
        r_vol[k]    <= VOL_W'(VOL_RESET);
        r_vol_sh[k] <= '0;
        r_smp_sh[k] <= '0;
      end else begin
        if (vol_we && (vol_addr == 3'(k)))
          r_vol[k] <= vol_wdata;
        if (w_start) begin
          r_vol_sh[k] <= r_vol[k];
          r_smp_sh[k] <= ch_in[k*IN_W +: IN_W];
        end
      end
    end
  end

  always_comb begin
    w_smp_cur = '0;
    w_vol_cur = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_smp_cur = r_smp_sh[k];
        w_vol_cur = r_vol_sh[k];
      end
    end
  end

  assign w_prod  = PROD_W'(w_smp_cur) * PROD_W'($signed({1'b0, w_vol_cur}));
  assign w_shift = r_acc >>> GAIN_SHIFT;
  assign w_sat   = OUT_W'(sat_s(64'(w_shift), OUT_W));

`ifdef SOUND_MIXER_DC_BLOCK_EN
  logic signed [OUT_W-1:0] r_sat;
  logic signed [OUT_W-1:0] r_x_prev;
  logic signed [OUT_W-1:0] r_y_prev;
  logic signed [OUT_W-1:0] w_dcb;

  // y = x - x_prev + y_prev - y_prev/256, pole just inside the unit circle.
  assign w_dcb = OUT_W'(sat_s(64'(r_sat) - 64'(r_x_prev) + 64'(r_y_prev)
                              - 64'(r_y_prev >>> 8), OUT_W));
`endif

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (sample_en) w_state_nxt = ST_MAC;
      ST_MAC:  if (w_last)    w_state_nxt = ST_OUT;
`ifdef SOUND_MIXER_DC_BLOCK_EN
      ST_OUT:  w_state_nxt = ST_DCB;
      ST_DCB:  w_state_nxt = ST_IDLE;
`else
      ST_OUT:  w_state_nxt = ST_IDLE;
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_acc     <= '0;
      r_idx     <= '0;
      r_mix     <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
`ifdef SOUND_MIXER_DC_BLOCK_EN
      r_sat     <= '0;
      r_x_prev  <= '0;
      r_y_prev  <= '0;
`endif
    end else begin
      r_valid <= 1'b0;
      if (sample_en && (r_state != ST_IDLE))
        r_overrun <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (sample_en) begin
            r_acc  <= '0;
            r_idx  <= '0;
            r_busy <= 1'b1;
          end
        end
        ST_MAC: begin
          r_acc <= r_acc + ACC_W'(w_prod);
          r_idx <= r_idx + IDX_W'(1);
        end
`ifdef SOUND_MIXER_DC_BLOCK_EN
        ST_OUT: r_sat <= w_sat;
        ST_DCB: begin
          r_mix    <= w_dcb;
          r_x_prev <= r_sat;
          r_y_prev <= w_dcb;
          r_valid  <= 1'b1;
          r_busy   <= 1'b0;
        end
`else
        ST_OUT: begin
          r_mix   <= w_sat;
          r_valid <= 1'b1;
          r_busy  <= 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end

  sound_dsm #(
    .OUT_W   (OUT_W)
  ) u_dsm (
    .clk     (clk),
    .n_reset (n_reset),
    .mix_in  (r_mix),
    .pwm_out (pwm_out)
  );

  assign mix_out   = r_mix;
  assign mix_valid = r_valid;
  assign busy      = r_busy;
  assign overrun   = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_sound_mixer_pwm.sv
// ============================================================================
// tb_sound_mixer_pwm : self-checking bench for sound_mixer_pwm (default build).
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_sound_mixer_pwm;

  localparam int CH_NUM     = 4;
  localparam int IN_W       = 16;
  localparam int VOL_W      = 4;
  localparam int GAIN_SHIFT = 3;
  localparam int OUT_W      = 16;
  localparam int VOL_RESET  = 8;
  localparam int LAT        = CH_NUM + 1;

  logic                    clk = 1'b0;
  logic                    n_reset = 1'b0;
  logic                    sample_en = 1'b0;
  logic [CH_NUM*IN_W-1:0]  ch_in = '0;
  logic                    vol_we = 1'b0;
  logic [2:0]              vol_addr = '0;
  logic [VOL_W-1:0]        vol_wdata = '0;
  logic signed [OUT_W-1:0] mix_out;
  logic                    mix_valid;
  logic                    busy;
  logic                    overrun;
  logic                    pwm_out;

  int checks   = 0;
  int failures = 0;
  int m_ch  [CH_NUM];
  int m_vol [CH_NUM];

  sound_mixer_pwm #(
    .CH_NUM     (CH_NUM),
    .IN_W       (IN_W),
    .VOL_W      (VOL_W),
    .GAIN_SHIFT (GAIN_SHIFT),
    .OUT_W      (OUT_W),
    .VOL_RESET  (VOL_RESET)
  ) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .sample_en  (sample_en),
    .ch_in      (ch_in),
    .vol_we     (vol_we),
    .vol_addr   (vol_addr),
    .vol_wdata  (vol_wdata),
    .mix_out    (mix_out),
    .mix_valid  (mix_valid),
    .busy       (busy),
    .overrun    (overrun),
    .pwm_out    (pwm_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: exact integer sum, floor-divided by the gain, clamped to OUT_W.
  function automatic int model_mix();
    longint sum;
    longint d;
    longint q;
    longint hi;
    sum = 0;
    for (int k = 0; k < CH_NUM; k++) sum += longint'(m_ch[k]) * longint'(m_vol[k]);
    d = longint'(1) << GAIN_SHIFT;
    q = sum / d;
    if (sum < 0 && (sum % d) != 0) q = q - 1;
    hi = (longint'(1) << (OUT_W - 1)) - 1;
    if (q > hi) q = hi;
    if (q < -hi - 1) q = -hi - 1;
    return int'(q);
  endfunction

  task automatic apply_ch();
    for (int k = 0; k < CH_NUM; k++) ch_in[k*IN_W +: IN_W] = IN_W'(m_ch[k]);
  endtask

  task automatic write_vol(input int addr, input int data);
    vol_we    = 1'b1;
    vol_addr  = 3'(addr);
    vol_wdata = VOL_W'(data);
    step();
    vol_we = 1'b0;
    if (addr < CH_NUM) m_vol[addr] = data;
  endtask

  task automatic start_frame();
    apply_ch();
    sample_en = 1'b1;
    step();
    sample_en = 1'b0;
  endtask

  task automatic wait_valid(output int lat, output int val);
    lat = -1;
    val = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (mix_valid) begin
        lat = i;
        val = int'(mix_out);
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) step();
    n_reset = 1'b1;
    for (int k = 0; k < CH_NUM; k++) m_vol[k] = VOL_RESET;
    step();
    checks++; if (mix_out !== '0)  begin failures++; $display("FAIL reset_mix_out got=%h want=0000", mix_out); end
    checks++; if (mix_valid !== 1'b0) begin failures++; $display("FAIL reset_mix_valid got=%b want=0", mix_valid); end
    checks++; if (busy !== 1'b0)   begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b want=0", overrun); end
    checks++; if (pwm_out !== 1'b0) begin failures++; $display("FAIL reset_pwm got=%b want=0", pwm_out); end
  endtask

  task automatic test_unity_sum();
    int lat, val;
    m_ch[3] = 1000; m_ch[2] = 2000; m_ch[1] = -500; m_ch[0] = 0;
    start_frame();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL unity_busy got=%b want=1", busy); end
    wait_valid(lat, val);
    checks++; if (lat != LAT) begin failures++; $display("FAIL unity_latency got=%0d want=%0d", lat, LAT); end
    checks++; if (val != 2500) begin failures++; $display("FAIL unity_value got=%0d want=2500", val); end
    step();
    checks++; if (busy !== 1'b0 || mix_valid !== 1'b0) begin
      failures++; $display("FAIL unity_idle got busy=%b valid=%b want 0/0", busy, mix_valid);
    end
  endtask

  task automatic test_saturation();
    int lat, val;
    for (int k = 0; k < CH_NUM; k++) write_vol(k, 15);
    for (int k = 0; k < CH_NUM; k++) m_ch[k] = 32767;
    start_frame();
    wait_valid(lat, val);
    checks++; if (lat != LAT) begin failures++; $display("FAIL satpos_latency got=%0d want=%0d", lat, LAT); end
    checks++; if (mix_out !== 16'h7FFF) begin failures++; $display("FAIL satpos_value got=%h want=7fff", mix_out); end
    for (int k = 0; k < CH_NUM; k++) m_ch[k] = -32768;
    start_frame();
    wait_valid(lat, val);
    checks++; if (lat != LAT) begin failures++; $display("FAIL satneg_latency got=%0d want=%0d", lat, LAT); end
    checks++; if (mix_out !== 16'h8000) begin failures++; $display("FAIL satneg_value got=%h want=8000", mix_out); end
    for (int k = 0; k < CH_NUM; k++) write_vol(k, 8);
  endtask

  task automatic test_vol_snapshot();
    int lat, val;
    for (int k = 0; k < CH_NUM; k++) m_ch[k] = 0;
    m_ch[1] = 4000;
    apply_ch();
    vol_we = 1'b1; vol_addr = 3'd1; vol_wdata = '0; sample_en = 1'b1;
    step();
    vol_we = 1'b0; sample_en = 1'b0;
    m_vol[1] = 0;
    wait_valid(lat, val);
    checks++; if (lat != LAT) begin failures++; $display("FAIL snap_latency got=%0d want=%0d", lat, LAT); end
    checks++; if (val != 4000) begin failures++; $display("FAIL snap_old_vol got=%0d want=4000", val); end
    step();
    start_frame();
    wait_valid(lat, val);
    checks++; if (val != 0) begin failures++; $display("FAIL snap_new_vol got=%0d want=0", val); end
    write_vol(1, 8);
    write_vol(4, 0);
    write_vol(7, 3);
    for (int k = 0; k < CH_NUM; k++) m_ch[k] = 1000;
    start_frame();
    wait_valid(lat, val);
    checks++; if (val != 4000 || val != model_mix()) begin
      failures++; $display("FAIL vol_addr_range got=%0d want=4000", val);
    end
  endtask

  task automatic test_back_to_back();
    int lat, val, exp_b;
    for (int k = 0; k < CH_NUM; k++) m_ch[k] = int'($urandom_range(0, 4000)) - 2000;
    start_frame();
    wait_valid(lat, val);
    checks++; if (val != model_mix()) begin failures++; $display("FAIL b2b_first got=%0d want=%0d", val, model_mix()); end
    for (int k = 0; k < CH_NUM; k++) m_ch[k] = int'($urandom_range(0, 4000)) - 2000;
    exp_b = model_mix();
    start_frame();
    wait_valid(lat, val);
    checks++; if (lat != LAT) begin failures++; $display("FAIL b2b_latency got=%0d want=%0d", lat, LAT); end
    checks++; if (val != exp_b) begin failures++; $display("FAIL b2b_second got=%0d want=%0d", val, exp_b); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL b2b_overrun got=%b want=0", overrun); end
  endtask

  task automatic test_random();
    int lat, val, exp_v;
    logic [15:0] r;
    for (int it = 0; it < 16; it++) begin
      for (int k = 0; k < CH_NUM; k++) write_vol(k, int'($urandom_range(0, 15)));
      if (it % 4 == 0) write_vol(int'($urandom_range(CH_NUM, 7)), int'($urandom_range(0, 15)));
      for (int k = 0; k < CH_NUM; k++) begin
        r = 16'($urandom);
        m_ch[k] = (it % 2 == 0) ? int'($signed(r)) : int'($urandom_range(0, 2000)) - 1000;
      end
      exp_v = model_mix();
      start_frame();
      wait_valid(lat, val);
      checks++; if (lat != LAT) begin failures++; $display("FAIL rand%0d_latency got=%0d want=%0d", it, lat, LAT); end
      checks++; if (val != exp_v) begin failures++; $display("FAIL rand%0d_value got=%0d want=%0d", it, val, exp_v); end
    end
  endtask

  task automatic test_overrun();
    int nvalid, val, exp_v;
    for (int k = 0; k < CH_NUM; k++) m_ch[k] = int'($urandom_range(0, 4000)) - 2000;
    exp_v = model_mix();
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_before got=%b want=0", overrun); end
    start_frame();
    step();
    ch_in = '1;
    sample_en = 1'b1;
    step();
    sample_en = 1'b0;
    nvalid = 0;
    val = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (mix_valid) begin
        nvalid++;
        if (nvalid == 1) val = int'(mix_out);
      end
    end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%b want=1", overrun); end
    checks++; if (nvalid != 1) begin failures++; $display("FAIL ovr_valid_count got=%0d want=1", nvalid); end
    checks++; if (val != exp_v) begin failures++; $display("FAIL ovr_value got=%0d want=%0d", val, exp_v); end
    step();
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b want=1", overrun); end
  endtask

  task automatic test_reset_mid_frame();
    int lat, val, nvalid;
    for (int k = 0; k < CH_NUM; k++) write_vol(k, 11);
    for (int k = 0; k < CH_NUM; k++) m_ch[k] = 3000 + 100 * k;
    start_frame();
    step();
    step();
    n_reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    checks++; if (mix_out !== '0) begin failures++; $display("FAIL rstmid_mix_out got=%h want=0000", mix_out); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rstmid_overrun got=%b want=0", overrun); end
    nvalid = 0;
    for (int i = 0; i < 3; i++) begin step(); if (mix_valid) nvalid++; end
    n_reset = 1'b1;
    for (int k = 0; k < CH_NUM; k++) m_vol[k] = VOL_RESET;
    for (int i = 0; i < 10; i++) begin step(); if (mix_valid) nvalid++; end
    checks++; if (nvalid != 0) begin failures++; $display("FAIL rstmid_no_valid got=%0d want=0", nvalid); end
    start_frame();
    wait_valid(lat, val);
    checks++; if (lat != LAT) begin failures++; $display("FAIL rstmid_fresh_latency got=%0d want=%0d", lat, LAT); end
    checks++; if (val != model_mix()) begin failures++; $display("FAIL rstmid_fresh_value got=%0d want=%0d", val, model_mix()); end
  endtask

  task automatic test_dsm_density();
    int lat, val, ones;
    for (int k = 0; k < CH_NUM; k++) m_ch[k] = 0;
    m_ch[0] = 16384;
    start_frame();
    wait_valid(lat, val);
    checks++; if (mix_out !== 16'h4000) begin failures++; $display("FAIL dsm_hold_4000 got=%h want=4000", mix_out); end
    step();
    step();
    ones = 0;
    for (int i = 0; i < 65536; i++) begin step(); if (pwm_out) ones++; end
    checks++; if (ones < 49151 || ones > 49153) begin
      failures++; $display("FAIL dsm_density got=%0d want=49152+-1", ones);
    end
    m_ch[0] = -32768;
    start_frame();
    wait_valid(lat, val);
    checks++; if (mix_out !== 16'h8000) begin failures++; $display("FAIL dsm_hold_8000 got=%h want=8000", mix_out); end
    step();
    step();
    ones = 0;
    for (int i = 0; i < 1024; i++) begin step(); if (pwm_out) ones++; end
    checks++; if (ones != 0) begin failures++; $display("FAIL dsm_zero got=%0d want=0", ones); end
  endtask

  initial begin
    test_reset();
    test_unity_sum();
    test_saturation();
    test_vol_snapshot();
    test_back_to_back();
    test_random();
    test_overrun();
    test_reset_mid_frame();
    test_dsm_density();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
